// File: rtl/branch_resolve_unit.sv
// Branch condition evaluation, 2-bit BHT prediction and branch statistics for the ID stage.
// Optional BHT storage is built only when BRU_BHT_EN is defined; otherwise prediction is static not-taken.
module branch_resolve_unit #(
   parameter int DATA_W    = 32,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] if_pc,
   output logic              pred_taken,
   input  logic              id_valid,
   input  logic              id_stall,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              id_pred_taken,
   input  logic [4:0]        ALUCode,
   input  logic [DATA_W-1:0] RsData,
   input  logic [DATA_W-1:0] RtData,
   output logic              Z,
   output logic              is_branch,
   output logic              mispredict,
   input  logic              clear_stats,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   localparam logic [4:0] ALU_BEQ  = 5'b01010;
   localparam logic [4:0] ALU_BNE  = 5'b01011;
   localparam logic [4:0] ALU_BGEZ = 5'b01100;
   localparam logic [4:0] ALU_BGTZ = 5'b01101;
   localparam logic [4:0] ALU_BLEZ = 5'b01110;
   localparam logic [4:0] ALU_BLTZ = 5'b01111;

   logic             rs_neg_s;
   logic             rs_zero_s;
   logic             rs_eq_rt_s;
   logic             z_s;
   logic             is_branch_s;
   logic             resolve_s;
   logic             mispredict_s;
   logic [CNT_W-1:0] branch_cnt_d, branch_cnt_q;
   logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;
   logic             unused_pc_bits;

   assign unused_pc_bits = ^{if_pc, id_pc};

   assign rs_neg_s   = RsData[DATA_W-1];
   assign rs_zero_s  = (RsData == {DATA_W{1'b0}});
   assign rs_eq_rt_s = (RsData == RtData);

   // Branch condition decode
   always_comb begin
      z_s         = 1'b0;
      is_branch_s = 1'b1;
      case (ALUCode)
         ALU_BEQ:  z_s = rs_eq_rt_s;
         ALU_BNE:  z_s = ~rs_eq_rt_s;
         ALU_BGEZ: z_s = ~rs_neg_s;
         ALU_BGTZ: z_s = ~rs_neg_s & ~rs_zero_s;
         ALU_BLEZ: z_s = rs_neg_s | rs_zero_s;
         ALU_BLTZ: z_s = rs_neg_s;
         default: begin
            z_s         = 1'b0;
            is_branch_s = 1'b0;
         end
      endcase
   end

   // Mispredict is deliberately not stall-gated so the flush request holds while ID is frozen.
   assign resolve_s    = id_valid & is_branch_s & ~id_stall;
   assign mispredict_s = id_valid & is_branch_s & (z_s ^ id_pred_taken);

   assign Z          = z_s;
   assign is_branch  = is_branch_s;
   assign mispredict = mispredict_s;

`ifdef BRU_BHT_EN
   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return nxt;
   endfunction

   logic [1:0]       bht_q [BHT_DEPTH];
   logic [1:0]       bht_d [BHT_DEPTH];
   logic [IDX_W-1:0] if_idx_s;
   logic [IDX_W-1:0] id_idx_s;

   assign if_idx_s   = if_pc[IDX_W+1:2];
   assign id_idx_s   = id_pc[IDX_W+1:2];
   assign pred_taken = bht_q[if_idx_s][1];

   // BHT next state: only the resolving entry moves
   always_comb begin
      bht_d = bht_q;
      if (resolve_s) begin
         bht_d[id_idx_s] = sat_step(bht_q[id_idx_s], z_s);
      end else begin
         bht_d[id_idx_s] = bht_q[id_idx_s];
      end
   end

   // BHT storage, reset to weakly not-taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         bht_q <= bht_d;
      end
   end
`else
   assign pred_taken = 1'b0;
`endif

   // Statistics next state: clear wins over increment, counts saturate
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (clear_stats) begin
         branch_cnt_d  = {CNT_W{1'b0}};
         mispred_cnt_d = {CNT_W{1'b0}};
      end else begin
         if (resolve_s && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            branch_cnt_d = branch_cnt_q;
         end
         if (resolve_s && mispredict_s && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            mispred_cnt_d = mispred_cnt_q;
         end
      end
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_cnt_q  <= {CNT_W{1'b0}};
         mispred_cnt_q <= {CNT_W{1'b0}};
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
